alu_share_ctrl: RTL

//  Shares one combinational 64-bit ALU (op[1:0]: 00 AND, 01 OR, 10 ADD; op[3]/op[2] invert a/b)

---
 rtl/alu_share_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: two-requester front end for one shared combinational ALU.
// A round-robin pick in IDLE decides who drives the ALU. The operands stay
// registered on alu_a/alu_b/alu_op until the next accept. The ALU result is
// captured at the end of a single EXEC cycle and held through the response
// handshake.
module alu_share_ctrl #(
  parameter int WIDTH = 64,
  parameter int OPW   = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic             resp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

  state_t           r_state;
  logic             r_rr;
  logic             r_owner;
  logic             r_resp0_valid;
  logic             r_resp1_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [OPW-1:0]   r_alu_op;
  logic [CNT_W-1:0] r_ops_done;

  logic w_grant1;
  logic w_idle;
  logic w_accept;
  logic w_resp_hs;

  // Low two opcode bits equal to 2'b11 select no ALU function.
  function automatic logic f_illegal_op(input logic [OPW-1:0] op);
    return (op[1:0] == 2'b11);
  endfunction

  // Round-robin pick: a lone requester wins, on a tie the one that did not win last.
  always_comb begin
    w_grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant1 = ~r_rr;
    end else if (req1_valid) begin
      w_grant1 = 1'b1;
    end else begin
      w_grant1 = 1'b0;
    end
  end

  // Only the owner's response ready can close an operation.
  always_comb begin
    w_resp_hs = 1'b0;
    if (r_owner) begin
      w_resp_hs = resp1_ready;
    end else begin
      w_resp_hs = resp0_ready;
    end
  end

  // Readies are held low while reset is asserted so nothing looks accepted.
  assign w_idle     = reset_n && (r_state == ST_IDLE);
  assign req0_ready = w_idle && req0_valid && !w_grant1;
  assign req1_ready = w_idle && req1_valid && w_grant1;
  assign w_accept   = req0_ready || req1_ready;

  // Control FSM: accept in IDLE, capture the ALU output in EXEC, hold the response in RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_rr          <= 1'b1;
      r_owner       <= 1'b0;
      r_resp0_valid <= 1'b0;
      r_resp1_valid <= 1'b0;
      r_result      <= '0;
      r_zero        <= 1'b0;
      r_err         <= 1'b0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_ops_done    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_a  <= w_grant1 ? req1_a  : req0_a;
            r_alu_b  <= w_grant1 ? req1_b  : req0_b;
            r_alu_op <= w_grant1 ? req1_op : req0_op;
            r_owner  <= w_grant1;
            r_rr     <= w_grant1;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (f_illegal_op(r_alu_op)) begin
            r_result <= '0;
            r_zero   <= 1'b1;
            r_err    <= 1'b1;
          end else begin
            r_result <= alu_result;
            r_zero   <= alu_zero;
            r_err    <= 1'b0;
          end
          r_resp0_valid <= ~r_owner;
          r_resp1_valid <= r_owner;
          r_state       <= ST_RESP;
        end
        ST_RESP: begin
          if (w_resp_hs) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_ops_done    <= r_ops_done + CNT_W'(1);
            r_state       <= ST_IDLE;
          end
        end
        default: begin
          r_resp0_valid <= 1'b0;
          r_resp1_valid <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp0_valid = r_resp0_valid;
  assign resp1_valid = r_resp1_valid;
  assign resp_result = r_result;
  assign resp_zero   = r_zero;
  assign resp_err    = r_err;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign ops_done    = r_ops_done;

endmodule
